uart_ctrl: RTL and testbench

Memory-mapped UART controller between the CPU's peripheral bus and the bit-level UART receiver/transmitter engines. It buffers received bytes in a small RX FIFO and holds one pending TX byte. A scheduler FSM issues transmit requests to the transmitter only when the transmitter is idle. It exposes status, sticky error flags and a level interrupt to the CPU.

---
 rtl/uart_ctrl.sv | 166 ++++++++++++++++
 tb/tb_uart_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: RX byte FIFO, single TX hold register with start scheduler,
// CON status/W1C flags and a level interrupt derived from registered state.
module uart_ctrl #(
  parameter int RX_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sel,
  input  logic [1:0]  i_addr,
  input  logic        i_wr,
  input  logic        i_rd,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_start,
  input  logic        i_tx_busy,
  output logic        o_irq
);

  localparam int PW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic        w_take, w_done_set;

  logic [7:0]  r_hold;
  logic        r_hold_full;
  logic [7:0]  r_tx_byte;
  logic        r_tx_start;
  logic        r_tx_irq_en, r_rx_irq_en;
  logic        r_rx_ovr, r_tx_drop, r_tx_done;

  logic [7:0]  r_fifo [RX_DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [4:0]  r_count;

  logic w_wr_txd, w_wr_con, w_rd_rxd;
  logic w_hold_acc, w_hold_drop;
  logic w_full, w_pop, w_push, w_ovr;
  logic [31:0] w_con;
  logic w_unused;

  assign w_wr_txd    = i_sel & i_wr & (i_addr == 2'd0);
  assign w_wr_con    = i_sel & i_wr & (i_addr == 2'd2);
  assign w_rd_rxd    = i_sel & i_rd & (i_addr == 2'd1);
  // A write into a full hold is still accepted when the scheduler drains it on the same edge.
  assign w_hold_acc  = w_wr_txd & (~r_hold_full | w_take);
  assign w_hold_drop = w_wr_txd & ~w_hold_acc;
  assign w_full      = (r_count == 5'(RX_DEPTH));
  assign w_pop       = w_rd_rxd & (r_count != 5'd0);
  assign w_push      = i_rx_valid & (~w_full | w_pop);
  assign w_ovr       = i_rx_valid & w_full & ~w_pop;
  assign w_unused    = ^{i_wdata[31:8], i_wdata[6], i_wdata[3:2]};

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_take         = 1'b0;
    w_done_set     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_hold_full && !i_tx_busy) begin
          w_take         = 1'b1;
          w_state_nxt    = S_WAIT_BUSY;
          w_wait_cnt_nxt = 2'd0;
        end
      end
      S_WAIT_BUSY: begin
        if (i_tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_wait_cnt == 2'd3) begin
          w_state_nxt = S_IDLE;
          w_done_set  = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 2'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy) begin
          w_state_nxt = S_IDLE;
          w_done_set  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sticky flags: a set event on the same edge overrides the W1C clear.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
      r_tx_byte   <= 8'd0;
      r_tx_start  <= 1'b0;
      r_tx_irq_en <= 1'b0;
      r_rx_irq_en <= 1'b0;
      r_rx_ovr    <= 1'b0;
      r_tx_drop   <= 1'b0;
      r_tx_done   <= 1'b0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= 5'd0;
    end else begin
      if (w_hold_acc) begin
        r_hold      <= i_wdata[7:0];
        r_hold_full <= 1'b1;
      end else if (w_take) begin
        r_hold_full <= 1'b0;
      end
      r_tx_start <= w_take;
      if (w_take) r_tx_byte <= r_hold;
      if (w_wr_con) begin
        r_tx_irq_en <= i_wdata[0];
        r_rx_irq_en <= i_wdata[1];
      end
      r_rx_ovr  <= w_ovr | (r_rx_ovr & ~(w_wr_con & i_wdata[4]));
      r_tx_drop <= w_hold_drop | (r_tx_drop & ~(w_wr_con & i_wdata[5]));
      r_tx_done <= w_done_set | (r_tx_done & ~(w_wr_con & i_wdata[7]) & ~w_wr_txd);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= i_rx_byte;
  end

  assign w_con = {19'd0, r_count, r_tx_done, (r_state != S_IDLE), r_tx_drop, r_rx_ovr,
                  (r_count != 5'd0), r_hold_full, r_rx_irq_en, r_tx_irq_en};

  always_comb begin
    o_rdata = 32'd0;
    if (i_sel && i_rd) begin
      case (i_addr)
        2'd0:    o_rdata = {24'd0, r_hold};
        2'd1:    o_rdata = (r_count != 5'd0) ? {24'd0, r_fifo[r_rd_ptr]} : 32'd0;
        2'd2:    o_rdata = w_con;
        default: o_rdata = 32'd0;
      endcase
    end
  end

  assign o_tx_byte  = r_tx_byte;
  assign o_tx_start = r_tx_start;
  assign o_irq      = (r_rx_irq_en & (r_count != 5'd0)) | (r_tx_irq_en & r_tx_done);

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: register vector table plus TX/RX scoreboards.
module tb_uart_ctrl;

  logic        clk = 1'b0;
  logic        reset, sel, wr, rd, rx_valid, tx_busy;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic [7:0]  rx_byte, tx_byte;
  logic        tx_start, irq;

  int checks = 0;
  int failures = 0;
  int n_start = 0;
  logic prev_start = 1'b0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  uart_ctrl #(.RX_DEPTH(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_sel(sel), .i_addr(addr), .i_wr(wr), .i_rd(rd),
    .i_wdata(wdata), .o_rdata(rdata), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
    .o_tx_byte(tx_byte), .o_tx_start(tx_start), .i_tx_busy(tx_busy), .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transmit scoreboard: every start must carry the next expected byte, never back to back.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      n_start++;
      check("start_not_consecutive", {31'd0, prev_start}, 32'd0);
      if (txq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tx_start: got byte 0x%0h expected no start", tx_byte);
      end else begin
        check("tx_byte_sb", {24'd0, tx_byte}, {24'd0, txq.pop_front()});
      end
    end
    prev_start = tx_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; wr = 1'b0; addr = 2'd0; wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; rd = 1'b1; addr = a;
    #1 d = rdata;
    tick();
    sel = 1'b0; rd = 1'b0; addr = 2'd0;
  endtask

  task automatic peek_con(output logic [31:0] d);
    sel = 1'b1; rd = 1'b1; addr = 2'd2;
    #1 d = rdata;
    sel = 1'b0; rd = 1'b0; addr = 2'd0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_byte = b; rx_valid = 1'b1;
    if (rxq.size() < 4) rxq.push_back(b);
    tick();
    rx_valid = 1'b0; rx_byte = 8'd0;
  endtask

  task automatic rx_read(input string name);
    logic [31:0] got;
    logic [31:0] exp;
    exp = (rxq.size() != 0) ? {24'd0, rxq.pop_front()} : 32'd0;
    bus_read(2'd1, got);
    check(name, got, exp);
  endtask

  typedef struct {
    logic        is_wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] v;
    int n0;

    vecs[0]  = '{1'b0, 2'd2, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 2'd3, 32'h0,        32'h0};
    vecs[3]  = '{1'b1, 2'd2, 32'hFFFFFFFF, 32'h0};
    vecs[4]  = '{1'b0, 2'd2, 32'h0,        32'h3};
    vecs[5]  = '{1'b1, 2'd3, 32'hFF,       32'h0};
    vecs[6]  = '{1'b0, 2'd3, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 2'd2, 32'h0,        32'h3};
    vecs[8]  = '{1'b1, 2'd2, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 2'd2, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 2'd0, 32'h0,        32'h0};

    // Reset with random inputs on the bus and engine sides
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sel = 1'($urandom); wr = 1'($urandom); rd = 1'($urandom); addr = 2'($urandom);
      wdata = $urandom; rx_byte = 8'($urandom); rx_valid = 1'($urandom); tx_busy = 1'($urandom);
      tick();
    end
    sel = 0; wr = 0; rd = 0; addr = 0; wdata = 0; rx_byte = 0; rx_valid = 0; tx_busy = 0;
    reset = 1'b1;
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].addr, vecs[i].wdata);
      end else begin
        bus_read(vecs[i].addr, v);
        check($sformatf("vec%0d", i), v, vecs[i].exp);
      end
    end

    // TX sequencing with transmitter busy handshake
    bus_write(2'd2, 32'h1);
    txq.push_back(8'hB5);
    sel = 1'b1; wr = 1'b1; addr = 2'd0; wdata = 32'hB5;
    tick();
    sel = 1'b0; wr = 1'b0; wdata = 32'd0;
    check("start_at_k", {31'd0, tx_start}, 32'd0);
    peek_con(v); check("hold_full_k", {31'd0, v[2]}, 32'd1);
    tick();
    check("start_at_k1", {31'd0, tx_start}, 32'd1);
    check("tx_byte_k1", {24'd0, tx_byte}, 32'hB5);
    peek_con(v); check("hold_clr_k1", {31'd0, v[2]}, 32'd0);
    check("active_k1", {31'd0, v[6]}, 32'd1);
    tick();
    check("start_at_k2", {31'd0, tx_start}, 32'd0);
    tx_busy = 1'b1;
    repeat (3) tick();
    n0 = n_start;
    txq.push_back(8'h0A);
    bus_write(2'd0, 32'h0A);
    peek_con(v); check("busy_wr_no_drop", {31'd0, v[5]}, 32'd0);
    check("busy_wr_held", {31'd0, v[2]}, 32'd1);
    repeat (15) tick();
    check("no_start_while_busy", n_start, n0);
    tx_busy = 1'b0;
    tick();
    peek_con(v); check("done_after_busy", {31'd0, v[7]}, 32'd1);
    check("irq_tx_done", {31'd0, irq}, 32'd1);
    check("no_start_on_done", {31'd0, tx_start}, 32'd0);
    tick();
    check("second_start", {31'd0, tx_start}, 32'd1);
    // Second byte: transmitter never acknowledges, scheduler times out
    bus_write(2'd2, 32'h81);
    peek_con(v); check("done_w1c", {31'd0, v[7]}, 32'd0);
    check("irq_after_w1c", {31'd0, irq}, 32'd0);
    repeat (2) tick();
    peek_con(v); check("active_s3", {31'd0, v[6]}, 32'd1);
    tick();
    peek_con(v); check("idle_s4", {31'd0, v[6]}, 32'd0);
    check("timeout_done", {31'd0, v[7]}, 32'd1);
    check("irq_timeout", {31'd0, irq}, 32'd1);

    // TX drop while transmitter stays busy
    tx_busy = 1'b1;
    txq.push_back(8'h11);
    bus_write(2'd0, 32'h11);
    check("irq_txd_clears_done", {31'd0, irq}, 32'd0);
    bus_write(2'd0, 32'h22);
    peek_con(v); check("tx_drop_set", {31'd0, v[5]}, 32'd1);
    bus_read(2'd0, v); check("txd_readback", v, 32'h11);
    n0 = n_start;
    repeat (3) tick();
    check("drop_no_start", n_start, n0);
    tx_busy = 1'b0;
    tick();
    check("start_after_drop", {31'd0, tx_start}, 32'd1);
    repeat (6) tick();
    bus_write(2'd2, 32'hA0);
    peek_con(v); check("drop_w1c", {24'd0, v[7:0]}, 32'h0);

    // RX ordering and interrupt
    bus_write(2'd2, 32'h2);
    rx_push(8'h0A); rx_push(8'h08); rx_push(8'h0C);
    peek_con(v); check("rx_count3", {27'd0, v[12:8]}, 32'd3);
    check("rx_nonempty", {31'd0, v[3]}, 32'd1);
    check("irq_rx", {31'd0, irq}, 32'd1);
    sel = 1'b1; addr = 2'd1;
    #1 check("rdata_no_rd", rdata, 32'd0);
    sel = 1'b0; addr = 2'd0;
    rx_read("rx_rd0"); rx_read("rx_rd1"); rx_read("rx_rd2");
    check("irq_rx_fall", {31'd0, irq}, 32'd0);
    rx_read("rx_rd_empty");

    // Overflow; overrun set on the same edge as a W1C must win
    rx_push(8'hB5); rx_push(8'h0A); rx_push(8'h08); rx_push(8'h0C);
    rx_byte = 8'h01; rx_valid = 1'b1;
    sel = 1'b1; wr = 1'b1; addr = 2'd2; wdata = 32'h12;
    tick();
    rx_valid = 1'b0; sel = 1'b0; wr = 1'b0; addr = 2'd0; wdata = 32'd0;
    peek_con(v); check("ovr_set_wins", {31'd0, v[4]}, 32'd1);
    check("ovr_count4", {27'd0, v[12:8]}, 32'd4);
    bus_write(2'd2, 32'h12);
    peek_con(v); check("ovr_w1c", {31'd0, v[4]}, 32'd0);
    rx_byte = 8'h77; rx_valid = 1'b1;
    sel = 1'b1; rd = 1'b1; addr = 2'd1;
    #1 check("full_pushpop_rd", rdata, {24'd0, rxq.pop_front()});
    rxq.push_back(8'h77);
    tick();
    rx_valid = 1'b0; sel = 1'b0; rd = 1'b0; addr = 2'd0;
    peek_con(v); check("full_pushpop_cnt", {27'd0, v[12:8]}, 32'd4);
    check("full_pushpop_no_ovr", {31'd0, v[4]}, 32'd0);
    for (int i = 0; i < 4; i++) rx_read($sformatf("ovr_rd%0d", i));
    rx_byte = 8'h5C; rx_valid = 1'b1;
    sel = 1'b1; rd = 1'b1; addr = 2'd1;
    #1 check("empty_rd_push", rdata, 32'd0);
    rxq.push_back(8'h5C);
    tick();
    rx_valid = 1'b0; sel = 1'b0; rd = 1'b0; addr = 2'd0;
    peek_con(v); check("empty_rd_push_cnt", {27'd0, v[12:8]}, 32'd1);
    rx_read("empty_rd_push_byte");

    // Reset in the middle of a transmission with bytes queued
    rx_push(8'h21); rx_push(8'h22);
    txq.push_back(8'h5A);
    bus_write(2'd0, 32'h5A);
    tick();
    tx_busy = 1'b1;
    repeat (2) tick();
    peek_con(v); check("pre_rst_active", {31'd0, v[6]}, 32'd1);
    check("pre_rst_count", {27'd0, v[12:8]}, 32'd2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    rxq.delete();
    peek_con(v); check("mid_rst_con", v, 32'd0);
    rx_read("mid_rst_rxd");
    n0 = n_start;
    txq.push_back(8'h6B);
    bus_write(2'd0, 32'h6B);
    repeat (5) tick();
    check("rst_busy_no_start", n_start, n0);
    tx_busy = 1'b0;
    repeat (10) tick();
    check("rst_one_start", n_start, n0 + 1);

    check("txq_drained", txq.size(), 0);
    check("rxq_drained", rxq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
